// File: rtl/axi_inf_write_burst_core.sv
// AXI4 write controller: splits one long write request into single-outstanding INCR bursts.
// Optional define AXI_4K_SPLIT_EN additionally clips each burst at the 4 KB address boundary.
module axi_inf_write_burst_core #(
   parameter int unsigned IDSIZE    = 3,
   parameter int unsigned ID        = 0,
   parameter int unsigned LSIZE     = 16,
   parameter int unsigned ASIZE     = 32,
   parameter int unsigned DSIZE     = 256,
   parameter int unsigned LENW      = 8,
   parameter int unsigned MAX_BURST = 256
) (
   input  logic              axi_aclk,
   input  logic              axi_resetn,
   input  logic              write_req,
   input  logic [LSIZE-1:0]  req_len,
   input  logic [ASIZE-1:0]  req_addr,
   output logic              req_resp,
   output logic              req_done,
   output logic              req_err,
   output logic              busy,
   output logic              pull_data_en,
   output logic [IDSIZE-1:0] axi_awid,
   output logic [ASIZE-1:0]  axi_awaddr,
   output logic [LENW-1:0]   axi_awlen,
   output logic [2:0]        axi_awsize,
   output logic [1:0]        axi_awburst,
   output logic              axi_awlock,
   output logic [3:0]        axi_awcache,
   output logic [2:0]        axi_awprot,
   output logic [3:0]        axi_awqos,
   output logic              axi_awvalid,
   input  logic              axi_awready,
   input  logic              axi_wvalid,
   input  logic              axi_wready,
   output logic              axi_wlast,
   output logic              axi_bready,
   input  logic [IDSIZE-1:0] axi_bid,
   input  logic [1:0]        axi_bresp,
   input  logic              axi_bvalid
);

   localparam int unsigned BYTES = DSIZE / 8;
   localparam int unsigned SZ    = $clog2(BYTES);
   localparam int unsigned BLW   = LENW + 1;
   localparam int unsigned CW0   = (LSIZE > BLW) ? LSIZE : BLW;
   localparam int unsigned CW    = (CW0 > 13) ? CW0 : 13;

   typedef enum logic [2:0] {
      S_IDLE, S_CALC, S_SET_VLD, S_WAIT_LAST, S_SET_BRDY, S_NEXT, S_DONE
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [ASIZE-1:0]  addr;
   logic [LSIZE-1:0]  rem;
   logic [BLW-1:0]    blen;
   logic [LENW-1:0]   bcnt;
   logic              err;
   logic [CW-1:0]     blen_c;
   logic              beat_c;
   logic              wlast_c;
   logic              own_b_c;
`ifdef AXI_4K_SPLIT_EN
   logic [CW-1:0]     room_c;
`endif

   assign axi_awid    = IDSIZE'(ID);
   assign axi_awsize  = 3'(SZ);
   assign axi_awburst = 2'b01;
   assign axi_awlock  = 1'b0;
   assign axi_awcache = 4'd0;
   assign axi_awprot  = 3'd0;
   assign axi_awqos   = 4'd0;

   assign beat_c    = axi_wvalid & axi_wready;
   assign wlast_c   = (state == S_WAIT_LAST) && (bcnt == axi_awlen);
   assign axi_wlast = wlast_c;
   assign own_b_c   = axi_bvalid && (axi_bid == IDSIZE'(ID));

   // Length of the next burst: remaining beats clipped to the burst cap (and the 4 KB page)
   always_comb begin
      blen_c = CW'(rem);
      if (blen_c > CW'(MAX_BURST)) blen_c = CW'(MAX_BURST);
`ifdef AXI_4K_SPLIT_EN
      room_c = CW'((13'h1000 - {1'b0, addr[11:0]}) >> SZ);
      if (blen_c > room_c) blen_c = room_c;
`endif
   end

   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) state <= S_IDLE;
      else             state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:      if (write_req) state_next = (req_len == '0) ? S_DONE : S_CALC;
         S_CALC:      state_next = S_SET_VLD;
         S_SET_VLD:   if (axi_awready) state_next = S_WAIT_LAST;
         S_WAIT_LAST: if (beat_c && wlast_c) state_next = S_SET_BRDY;
         S_SET_BRDY:  if (own_b_c) state_next = S_NEXT;
         S_NEXT:      state_next = (rem == LSIZE'(blen)) ? S_DONE : S_CALC;
         S_DONE:      state_next = S_IDLE;
         default:     state_next = S_IDLE;
      endcase
   end

   // Handshake outputs are decoded from the next state so they are high exactly in their state
   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         addr         <= '0;
         rem          <= '0;
         blen         <= '0;
         bcnt         <= '0;
         err          <= 1'b0;
         axi_awaddr   <= '0;
         axi_awlen    <= '0;
         axi_awvalid  <= 1'b0;
         axi_bready   <= 1'b0;
         pull_data_en <= 1'b0;
         req_resp     <= 1'b0;
         req_done     <= 1'b0;
         req_err      <= 1'b0;
         busy         <= 1'b0;
      end else begin
         req_resp     <= (state == S_IDLE) && write_req;
         req_done     <= (state_next == S_DONE);
         req_err      <= (state_next == S_DONE) && err;
         busy         <= (state_next != S_IDLE);
         axi_awvalid  <= (state_next == S_SET_VLD);
         pull_data_en <= (state_next == S_WAIT_LAST);
         axi_bready   <= (state_next == S_SET_BRDY);
         case (state)
            S_IDLE: begin
               if (write_req) begin
                  addr <= req_addr;
                  rem  <= req_len;
               end
            end
            S_CALC: begin
               blen       <= BLW'(blen_c);
               axi_awaddr <= addr;
               axi_awlen  <= LENW'(blen_c - CW'(1));
            end
            S_WAIT_LAST: begin
               if (beat_c) bcnt <= wlast_c ? '0 : bcnt + LENW'(1);
            end
            S_SET_BRDY: begin
               if (own_b_c) err <= err | (axi_bresp != 2'b00);
            end
            S_NEXT: begin
               addr <= addr + (ASIZE'(blen) << SZ);
               rem  <= rem - LSIZE'(blen);
            end
            S_DONE: err <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_inf_write_burst_core.sv
// Self-checking bench for axi_inf_write_burst_core: randomized AXI slave and data mover
// compared against a burst-splitting reference model.
module tb_axi_inf_write_burst_core;

   localparam int unsigned IDSIZE    = 3;
   localparam int unsigned ID        = 0;
   localparam int unsigned LSIZE     = 16;
   localparam int unsigned ASIZE     = 32;
   localparam int unsigned DSIZE     = 256;
   localparam int unsigned LENW      = 8;
   localparam int unsigned MAX_BURST = 256;
   localparam int unsigned BYTES     = DSIZE / 8;

   logic              axi_aclk = 1'b0;
   logic              axi_resetn = 1'b0;
   logic              write_req = 1'b0;
   logic [LSIZE-1:0]  req_len = '0;
   logic [ASIZE-1:0]  req_addr = '0;
   logic              req_resp, req_done, req_err, busy, pull_data_en;
   logic [IDSIZE-1:0] axi_awid;
   logic [ASIZE-1:0]  axi_awaddr;
   logic [LENW-1:0]   axi_awlen;
   logic [2:0]        axi_awsize;
   logic [1:0]        axi_awburst;
   logic              axi_awlock;
   logic [3:0]        axi_awcache;
   logic [2:0]        axi_awprot;
   logic [3:0]        axi_awqos;
   logic              axi_awvalid;
   logic              axi_awready = 1'b0;
   logic              axi_wvalid = 1'b0;
   logic              axi_wready = 1'b0;
   logic              axi_wlast;
   logic              axi_bready;
   logic [IDSIZE-1:0] axi_bid = '0;
   logic [1:0]        axi_bresp = '0;
   logic              axi_bvalid = 1'b0;

   axi_inf_write_burst_core #(
      .IDSIZE(IDSIZE), .ID(ID), .LSIZE(LSIZE), .ASIZE(ASIZE),
      .DSIZE(DSIZE), .LENW(LENW), .MAX_BURST(MAX_BURST)
   ) dut (
      .axi_aclk(axi_aclk), .axi_resetn(axi_resetn),
      .write_req(write_req), .req_len(req_len), .req_addr(req_addr),
      .req_resp(req_resp), .req_done(req_done), .req_err(req_err),
      .busy(busy), .pull_data_en(pull_data_en),
      .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
      .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awlock(axi_awlock),
      .axi_awcache(axi_awcache), .axi_awprot(axi_awprot), .axi_awqos(axi_awqos),
      .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
      .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wlast(axi_wlast),
      .axi_bready(axi_bready), .axi_bid(axi_bid), .axi_bresp(axi_bresp),
      .axi_bvalid(axi_bvalid)
   );

   always #5 axi_aclk = ~axi_aclk;

   int errors = 0;
   int checks = 0;

   // slave / data mover controls
   bit rand_ready = 1'b0;
   int aw_stall = 0;
   bit foreign_pending = 1'b0;
   int err_burst = -1;
   int b_own_idx = 0;
   int owed = 0;
   bit b_prev_hs = 1'b0;

   logic [31:0] aw_addr_q[$];
   int          aw_len_q[$];
   bit          w_last_q[$];

   // observations of one request
   int obs_resp_cnt, obs_done_cnt, obs_resp_cyc, obs_done_cyc;
   bit obs_err, obs_timeout;

   // expected bursts from the model
   logic [31:0] exp_addr[$];
   int          exp_len[$];

   // AXI slave and data mover, all activity on the falling edge
   always @(negedge axi_aclk) begin
      if (!axi_resetn) begin
         axi_awready = 1'b0;
         axi_wvalid  = 1'b0;
         axi_wready  = 1'b0;
         axi_bvalid  = 1'b0;
         owed        = 0;
         b_prev_hs   = 1'b0;
      end else begin
         if (aw_stall > 0 && axi_awvalid) begin
            axi_awready = 1'b0;
            aw_stall--;
         end else begin
            axi_awready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
         end
         if (axi_awvalid && axi_awready) begin
            aw_addr_q.push_back(axi_awaddr);
            aw_len_q.push_back(int'(axi_awlen));
         end
         if (b_prev_hs) axi_bvalid = 1'b0;
         if (!axi_bvalid && owed > 0 && (!rand_ready || $urandom_range(0, 1) == 1)) begin
            if (foreign_pending) begin
               axi_bid = 3'(ID + 1);
               axi_bresp = 2'b10;
               foreign_pending = 1'b0;
            end else begin
               axi_bid = 3'(ID);
               axi_bresp = (b_own_idx == err_burst) ? 2'b10 : 2'b00;
               b_own_idx++;
               owed--;
            end
            axi_bvalid = 1'b1;
         end
         b_prev_hs = axi_bvalid && axi_bready;
         axi_wvalid = pull_data_en && (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
         axi_wready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (axi_wvalid && axi_wready) begin
            w_last_q.push_back(axi_wlast);
            if (axi_wlast) owed++;
         end
      end
   end

   // reference: split a request into bursts using the block's length rules
   function automatic void model_bursts(input logic [31:0] a, input int l);
      int b;
      int room;
      exp_addr.delete();
      exp_len.delete();
      room = 0;
      while (l > 0) begin
         b = (l < int'(MAX_BURST)) ? l : int'(MAX_BURST);
`ifdef AXI_4K_SPLIT_EN
         room = (4096 - int'(a % 4096)) / int'(BYTES);
         if (b > room) b = room;
`endif
         exp_addr.push_back(a);
         exp_len.push_back(b);
         a = a + 32'(b * int'(BYTES));
         l = l - b;
      end
   endfunction

   task automatic run_request(input logic [31:0] a, input int l);
      bit finished;
      aw_addr_q.delete();
      aw_len_q.delete();
      w_last_q.delete();
      b_own_idx = 0;
      obs_resp_cnt = 0; obs_done_cnt = 0; obs_resp_cyc = -1; obs_done_cyc = -1;
      obs_err = 1'b0; obs_timeout = 1'b1;
      finished = 1'b0;
      @(negedge axi_aclk);
      write_req = 1'b1;
      req_addr = a;
      req_len = 16'(l);
      @(negedge axi_aclk);
      write_req = 1'b0;
      for (int c = 0; c < 20000 && !finished; c++) begin
         if (req_resp) begin obs_resp_cnt++; obs_resp_cyc = c; end
         if (req_done) begin obs_done_cnt++; obs_done_cyc = c; obs_err = req_err; end
         if (obs_done_cnt > 0 && c >= obs_done_cyc + 4) begin
            finished = 1'b1;
            obs_timeout = 1'b0;
         end else begin
            @(negedge axi_aclk);
         end
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge axi_aclk);
      checks++;
      if ({req_resp, req_done, req_err, busy, pull_data_en, axi_awvalid, axi_wlast, axi_bready} !== 8'd0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 00000000",
                  {req_resp, req_done, req_err, busy, pull_data_en, axi_awvalid, axi_wlast, axi_bready});
      end
      checks++;
      if (axi_awaddr !== 32'd0 || axi_awlen !== 8'd0) begin
         errors++;
         $display("FAIL reset_aw: awaddr=%h awlen=%0d expected 0/0", axi_awaddr, axi_awlen);
      end
      checks++;
      if (axi_awsize !== 3'd5 || axi_awburst !== 2'b01 || axi_awid !== 3'd0 ||
          {axi_awlock, axi_awcache, axi_awprot, axi_awqos} !== 12'd0) begin
         errors++;
         $display("FAIL reset_ties: awsize=%0d awburst=%b awid=%0d expected 5/01/0", axi_awsize, axi_awburst, axi_awid);
      end
      axi_resetn = 1'b1;
      repeat (2) @(negedge axi_aclk);
   endtask

   task automatic test_single;
      rand_ready = 1'b0;
      run_request(32'h1000, 4);
      checks++;
      if (obs_timeout || obs_done_cnt != 1 || obs_resp_cnt != 1) begin
         errors++;
         $display("FAIL single_pulses: done=%0d resp=%0d timeout=%0d expected 1/1/0", obs_done_cnt, obs_resp_cnt, obs_timeout);
      end
      checks++;
      if (aw_addr_q.size() != 1 || aw_addr_q[0] !== 32'h1000 || aw_len_q[0] != 3) begin
         errors++;
         $display("FAIL single_aw: count=%0d addr=%h len=%0d expected 1/1000/3", aw_addr_q.size(),
                  (aw_addr_q.size() > 0) ? aw_addr_q[0] : 32'hx, (aw_len_q.size() > 0) ? aw_len_q[0] : -1);
      end
      checks++;
      if (w_last_q.size() != 4 || w_last_q[0] || w_last_q[1] || w_last_q[2] || !w_last_q[3]) begin
         errors++;
         $display("FAIL single_wlast: beats=%0d expected 4 with wlast only on the 4th", w_last_q.size());
      end
      checks++;
      if (obs_err !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_err_busy: err=%b busy=%b expected 0/0", obs_err, busy);
      end
   endtask

   task automatic test_multi;
      int run, bi, bad;
      rand_ready = 1'b0;
      run_request(32'h0, 600);
      model_bursts(32'h0, 600);
      checks++;
      if (obs_timeout || obs_done_cnt != 1) begin
         errors++;
         $display("FAIL multi_done: done=%0d timeout=%0d expected 1/0", obs_done_cnt, obs_timeout);
      end
`ifndef AXI_4K_SPLIT_EN
      checks++;
      if (aw_len_q.size() != 3 || aw_len_q[0] != 255 || aw_len_q[1] != 255 || aw_len_q[2] != 87 ||
          aw_addr_q[1] !== 32'h2000 || aw_addr_q[2] !== 32'h4000) begin
         errors++;
         $display("FAIL multi_plan: count=%0d expected 3 bursts 255/255/87 at 0/2000/4000", aw_len_q.size());
      end
`endif
      checks++;
      bad = (aw_addr_q.size() != exp_addr.size()) ? 1 : 0;
      for (int i = 0; i < aw_addr_q.size() && bad == 0; i++)
         if (aw_addr_q[i] !== exp_addr[i] || aw_len_q[i] != exp_len[i] - 1) bad = 1;
      if (bad != 0) begin
         errors++;
         $display("FAIL multi_aw: got %0d bursts expected %0d", aw_addr_q.size(), exp_addr.size());
      end
      run = 0; bi = 0; bad = 0;
      foreach (w_last_q[i]) begin
         run++;
         if (w_last_q[i]) begin
            if (bi >= exp_len.size() || run != exp_len[bi]) bad++;
            bi++;
            run = 0;
         end
      end
      checks++;
      if (bad != 0 || run != 0 || bi != exp_len.size()) begin
         errors++;
         $display("FAIL multi_beats: bad=%0d tail=%0d bursts=%0d expected 0/0/%0d", bad, run, bi, exp_len.size());
      end
   endtask

   task automatic test_4k;
      rand_ready = 1'b0;
      run_request(32'h0F80, 16);
      checks++;
`ifdef AXI_4K_SPLIT_EN
      if (aw_addr_q.size() != 2 || aw_addr_q[0] !== 32'h0F80 || aw_len_q[0] != 3 ||
          aw_addr_q[1] !== 32'h1000 || aw_len_q[1] != 11) begin
         errors++;
         $display("FAIL split_4k: count=%0d expected 2 bursts 3@F80 and 11@1000", aw_addr_q.size());
      end
`else
      if (aw_addr_q.size() != 1 || aw_addr_q[0] !== 32'h0F80 || aw_len_q[0] != 15) begin
         errors++;
         $display("FAIL no_split_4k: count=%0d expected 1 burst 15@F80", aw_addr_q.size());
      end
`endif
   endtask

   task automatic test_bresp;
      rand_ready = 1'b0;
      foreign_pending = 1'b1;
      err_burst = -1;
      run_request(32'h9000, 3);
      checks++;
      if (obs_timeout || obs_done_cnt != 1 || obs_err !== 1'b0 || aw_addr_q.size() != 1) begin
         errors++;
         $display("FAIL foreign_ignored: done=%0d err=%b aws=%0d expected 1/0/1", obs_done_cnt, obs_err, aw_addr_q.size());
      end
      foreign_pending = 1'b1;
      err_burst = 1;
      run_request(32'h0, 300);
      model_bursts(32'h0, 300);
      checks++;
      if (obs_timeout || obs_done_cnt != 1 || obs_err !== 1'b1 || aw_addr_q.size() != exp_addr.size()) begin
         errors++;
         $display("FAIL slverr: done=%0d err=%b aws=%0d expected 1/1/%0d", obs_done_cnt, obs_err, aw_addr_q.size(), exp_addr.size());
      end
      err_burst = -1;
      run_request(32'h8000, 5);
      checks++;
      if (obs_timeout || obs_done_cnt != 1 || obs_err !== 1'b0) begin
         errors++;
         $display("FAIL err_cleared: done=%0d err=%b expected 1/0", obs_done_cnt, obs_err);
      end
   endtask

   task automatic test_zero_len;
      rand_ready = 1'b0;
      run_request(32'h3000, 0);
      checks++;
      if (obs_timeout || obs_resp_cnt != 1 || obs_done_cnt != 1 || obs_resp_cyc > obs_done_cyc || obs_err !== 1'b0) begin
         errors++;
         $display("FAIL zero_len_pulses: resp=%0d@%0d done=%0d@%0d err=%b expected one resp not after one done, err 0",
                  obs_resp_cnt, obs_resp_cyc, obs_done_cnt, obs_done_cyc, obs_err);
      end
      checks++;
      if (aw_addr_q.size() != 0 || w_last_q.size() != 0) begin
         errors++;
         $display("FAIL zero_len_traffic: aws=%0d beats=%0d expected 0/0", aw_addr_q.size(), w_last_q.size());
      end
   endtask

   task automatic test_aw_stall;
      logic [31:0] cap_addr;
      logic [7:0]  cap_len;
      int          unstable;
      bit          seen;
      rand_ready = 1'b0;
      aw_stall = 10;
      unstable = 0;
      seen = 1'b0;
      cap_addr = '0;
      cap_len = '0;
      fork
         run_request(32'h2000, 8);
         begin
            for (int c = 0; c < 200 && !seen; c++) begin
               @(negedge axi_aclk);
               if (axi_awvalid) seen = 1'b1;
            end
            cap_addr = axi_awaddr;
            cap_len = axi_awlen;
            for (int k = 0; k < 10; k++) begin
               if (axi_awvalid !== 1'b1 || axi_awaddr !== cap_addr || axi_awlen !== cap_len) unstable++;
               @(negedge axi_aclk);
            end
         end
      join
      checks++;
      if (!seen || unstable != 0 || cap_addr !== 32'h2000 || cap_len !== 8'd7) begin
         errors++;
         $display("FAIL aw_stall_stable: seen=%b unstable=%0d addr=%h len=%0d expected 1/0/2000/7", seen, unstable, cap_addr, cap_len);
      end
      checks++;
      if (obs_timeout || obs_done_cnt != 1 || aw_addr_q.size() != 1 || w_last_q.size() != 8) begin
         errors++;
         $display("FAIL aw_stall_done: done=%0d aws=%0d beats=%0d expected 1/1/8", obs_done_cnt, aw_addr_q.size(), w_last_q.size());
      end
      aw_stall = 0;
   endtask

   task automatic test_reset_mid;
      bit hit;
      int stray;
      rand_ready = 1'b0;
      w_last_q.delete();
      hit = 1'b0;
      stray = 0;
      @(negedge axi_aclk);
      write_req = 1'b1;
      req_addr = 32'h5000;
      req_len = 16'd8;
      @(negedge axi_aclk);
      write_req = 1'b0;
      for (int c = 0; c < 50 && !hit; c++) begin
         @(negedge axi_aclk);
         #1;
         if (w_last_q.size() == 3) hit = 1'b1;
      end
      axi_resetn = 1'b0;
      #1;
      checks++;
      if (!hit || {req_resp, req_done, req_err, busy, pull_data_en, axi_awvalid, axi_wlast, axi_bready} !== 8'd0 ||
          axi_awaddr !== 32'd0 || axi_awlen !== 8'd0) begin
         errors++;
         $display("FAIL reset_mid_async: hit=%b ctrl=%b awaddr=%h awlen=%0d expected 1/0/0/0", hit,
                  {req_resp, req_done, req_err, busy, pull_data_en, axi_awvalid, axi_wlast, axi_bready}, axi_awaddr, axi_awlen);
      end
      repeat (3) @(negedge axi_aclk);
      axi_resetn = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge axi_aclk);
         if (req_done || busy || axi_awvalid) stray++;
      end
      checks++;
      if (stray != 0) begin
         errors++;
         $display("FAIL reset_mid_quiet: %0d cycles with activity expected 0", stray);
      end
      run_request(32'h6000, 20);
      checks++;
      if (obs_timeout || obs_done_cnt != 1 || obs_err !== 1'b0 || aw_addr_q.size() != 1 ||
          aw_addr_q[0] !== 32'h6000 || aw_len_q[0] != 19 || w_last_q.size() != 20) begin
         errors++;
         $display("FAIL reset_mid_rerun: done=%0d aws=%0d beats=%0d expected 1/1/20", obs_done_cnt, aw_addr_q.size(), w_last_q.size());
      end
   endtask

   task automatic test_random;
      logic [31:0] a;
      int l, run, bi, bad;
      bit exp_err;
      rand_ready = 1'b1;
      for (int it = 0; it < 6; it++) begin
         a = $urandom & 32'h0003_FFE0;
         l = $urandom_range(1, 700);
         err_burst = int'($urandom_range(0, 3)) - 1;
         foreign_pending = $urandom_range(0, 1) == 1;
         model_bursts(a, l);
         exp_err = (err_burst >= 0) && (err_burst < exp_len.size());
         run_request(a, l);
         checks++;
         if (obs_timeout || obs_done_cnt != 1 || obs_resp_cnt != 1 || obs_err !== exp_err) begin
            errors++;
            $display("FAIL random_done[%0d]: done=%0d resp=%0d err=%b expected 1/1/%b", it, obs_done_cnt, obs_resp_cnt, obs_err, exp_err);
         end
         checks++;
         bad = (aw_addr_q.size() != exp_addr.size()) ? 1 : 0;
         for (int i = 0; i < aw_addr_q.size() && bad == 0; i++)
            if (aw_addr_q[i] !== exp_addr[i] || aw_len_q[i] != exp_len[i] - 1) bad = 1;
         if (bad != 0) begin
            errors++;
            $display("FAIL random_aw[%0d]: addr=%h len=%0d got %0d bursts expected %0d", it, a, l, aw_addr_q.size(), exp_addr.size());
         end
         run = 0; bi = 0; bad = 0;
         foreach (w_last_q[i]) begin
            run++;
            if (w_last_q[i]) begin
               if (bi >= exp_len.size() || run != exp_len[bi]) bad++;
               bi++;
               run = 0;
            end
         end
         checks++;
         if (bad != 0 || run != 0 || bi != exp_len.size()) begin
            errors++;
            $display("FAIL random_beats[%0d]: bad=%0d tail=%0d bursts=%0d expected 0/0/%0d", it, bad, run, bi, exp_len.size());
         end
      end
      err_burst = -1;
      foreign_pending = 1'b0;
      rand_ready = 1'b0;
   endtask

   initial begin
      test_reset;
      test_single;
      test_multi;
      test_4k;
      test_bresp;
      test_zero_len;
      test_aw_stall;
      test_reset_mid;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/axi_inf_write_burst_core.md
Name: axi_inf_write_burst_core

Overview:
AXI4 write-channel controller that takes one long write request and splits it into a sequence of INCR bursts. Each burst is limited by MAX_BURST and, optionally, by the 4 KB address boundary. The block drives AW and B handshakes, generates wlast, and tells the external data mover when to present W beats. It also reports an accumulated error status at request completion. It sits between the VDMA write-side FIFO logic and the AXI interconnect.

Parameters:
IDSIZE, 3, AXI ID width
ID, 0, fixed AWID; B responses with any other BID are discarded
LSIZE, 16, width of req_len (total beats per request)
ASIZE, 32, address width
DSIZE, 256, data width in bits; power of two, 8..1024; BYTES = DSIZE/8
LENW, 8, width of axi_awlen
MAX_BURST, 256, maximum beats per burst; 1..2^LENW

Ports:
axi_aclk  in  1  clock
axi_resetn  in  1  async active-low reset
write_req  in  1  request strobe, sampled in IDLE only
req_len  in  LSIZE  total beats, sampled with write_req
req_addr  in  ASIZE  start byte address, BYTES-aligned, sampled with write_req
req_resp  out  1  1-cycle pulse: request accepted
req_done  out  1  1-cycle pulse: all bursts responded
req_err  out  1  valid with req_done: 1 if any BRESP != OKAY
busy  out  1  high from acceptance to req_done
pull_data_en  out  1  data mover may present W beats
axi_awid  out  IDSIZE  = ID
axi_awaddr  out  ASIZE  current burst address
axi_awlen  out  LENW  current burst beats - 1
axi_awsize  out  3  log2(BYTES), constant
axi_awburst  out  2  2'b01 INCR
axi_awlock/awcache/awprot/awqos  out  1/4/3/4  all zero
axi_awvalid  out  1  address valid
axi_awready  in  1  address ready
axi_wvalid  in  1  W valid (from data mover)
axi_wready  in  1  W ready
axi_wlast  out  1  last beat of current burst
axi_bready  out  1  response ready
axi_bid  in  IDSIZE  response ID
axi_bresp  in  2  response code
axi_bvalid  in  1  response valid

Behaviour:
- Reset: all outputs 0, including awaddr and awlen. Constant ties hold their values. State IDLE, counters 0, error flag 0. Reset asserted mid-burst aborts immediately; no completion pulse is issued.
- States: IDLE, CALC, SET_VLD, WAIT_LAST, SET_BRDY, NEXT, DONE.
- IDLE: on write_req, latch addr and rem=req_len, then pulse req_resp next cycle.
  - If req_len==0: go to DONE with no AXI traffic.
  - Otherwise go to CALC.
- CALC (1 cycle): blen = min(rem, MAX_BURST, [AXI_4K_SPLIT_EN] (4096 - addr[11:0]) / BYTES). Register awaddr=addr and awlen=blen-1.
- SET_VLD: awvalid=1 and held stable until awready is sampled high; then go to WAIT_LAST.
- WAIT_LAST:
  - pull_data_en=1; beat counter bcnt counts wvalid&wready.
  - axi_wlast = WAIT_LAST & (bcnt==blen-1). It is combinational from registered state, so wlast is valid on the same cycle as the beat.
  - The beat with wvalid&wready&wlast clears bcnt and moves to SET_BRDY; pull_data_en drops the following cycle.
  - W beats arriving outside WAIT_LAST are not counted. The data mover must respect pull_data_en.
- SET_BRDY: bready=1.
  - On bvalid with bid==ID: err |= (bresp!=2'b00), then go to NEXT.
  - On bvalid with bid!=ID: the response is consumed and ignored; stay in SET_BRDY.
- NEXT: addr += blen*BYTES (mod 2^ASIZE), rem -= blen. If rem==0 go to DONE, else go to CALC.
- DONE: pulse req_done and drive req_err=err for the same cycle; clear err; return to IDLE.
- busy=0 only in IDLE.
- write_req outside IDLE is ignored; there is no queueing.
- Exactly one burst is outstanding at a time; AW for burst n+1 never precedes B of burst n.
- Per-burst overhead: CALC and NEXT each add 1 cycle.

Optional Feature:
AXI_4K_SPLIT_EN:
- Defined: blen is additionally clipped so that no burst crosses a 4096-byte boundary.
- Undefined: the clip term is removed; the caller guarantees no crossing.

Test Plan:
- DSIZE=256, req_addr=0x1000, req_len=4, awready/wready always 1 -> one AW (awaddr=0x1000, awlen=3, awsize=5); wlast on 4th beat; req_done=1 with req_err=0.
- MAX_BURST=256, req_len=600 -> bursts awlen 255/255/87 at 0x0, 0x2000, 0x4000; exactly one req_done.
- AXI_4K_SPLIT_EN defined, DSIZE=256, req_addr=0x0F80, req_len=16 -> bursts awlen=3 at 0x0F80 and awlen=11 at 0x1000.
- Second burst returns bresp=2'b10; a foreign-ID bvalid is injected first -> foreign response is ignored; req_done has req_err=1; the next request reports req_err=0.
- req_len=0 -> req_resp then req_done, no awvalid. awready held low for 10 cycles -> awvalid and awaddr stay stable throughout.
- Deassert axi_resetn during the 3rd beat of WAIT_LAST -> all outputs 0 asynchronously; a new request after release runs cleanly from IDLE.
